lcd_refresh_controller: RTL and testbench



---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_nibble_writer.sv | 87 ++++++++
 rtl/lcd_refresh_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_refresh_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and timing defaults for the
// character LCD refresh path.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC  = 8'h28;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    localparam logic [3:0] NIB_INIT3 = 4'h3;
    localparam logic [3:0] NIB_INIT2 = 4'h2;

    localparam int DEF_POWERUP_CYC   = 750000;
    localparam int DEF_INIT_GAP1_CYC = 205000;
    localparam int DEF_INIT_GAP2_CYC = 5000;
    localparam int DEF_SETUP_CYC     = 2;
    localparam int DEF_E_CYC         = 12;
    localparam int DEF_HOLD_CYC      = 1;
    localparam int DEF_NIB_GAP_CYC   = 50;
    localparam int DEF_BYTE_GAP_CYC  = 2000;
    localparam int DEF_CLEAR_GAP_CYC = 82000;

    typedef enum logic [3:0] {
        PWR_WAIT, N3A, N3B, N3C, N2,
        FUNC, ENTRY, DISP, CLR,
        FRAME_START, CMD_L1, FETCH1, FETCH2,
        CHAR, CMD_L2
    } lcdState_t;

    typedef enum logic [2:0] {
        NW_IDLE, NW_SETUP, NW_E, NW_HOLD, NW_GAP
    } nwPhase_t;

    function automatic int cntWidth(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// One 4-bit LCD write: setup, E strobe, hold, then a caller-chosen
// idle gap before the done pulse. All phase lengths must be >= 1.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int E_CYC     = DEF_E_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CW        = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    nib,
    input  logic          rs,
    input  logic [CW-1:0] gap,
    output logic [3:0]    lcdData,
    output logic          lcdRs,
    output logic          lcdE,
    output logic          done
);

    nwPhase_t      phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gapQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= NW_IDLE;
            cnt     <= '0;
            gapQ    <= '0;
            lcdData <= '0;
            lcdRs   <= 1'b0;
            lcdE    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (phase)
                NW_IDLE: begin
                    if (start) begin
                        lcdData <= nib;
                        lcdRs   <= rs;
                        gapQ    <= gap;
                        cnt     <= CW'(SETUP_CYC - 1);
                        phase   <= NW_SETUP;
                    end
                end
                NW_SETUP: begin
                    if (cnt == '0) begin
                        lcdE  <= 1'b1;
                        cnt   <= CW'(E_CYC - 1);
                        phase <= NW_E;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                NW_E: begin
                    if (cnt == '0) begin
                        lcdE  <= 1'b0;
                        cnt   <= CW'(HOLD_CYC - 1);
                        phase <= NW_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                NW_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= gapQ - CW'(1);
                        phase <= NW_GAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                NW_GAP: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        phase <= NW_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: phase <= NW_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_refresh_controller.sv
// HD44780 init sequence followed by an endless refresh of one of the
// two 32-byte character RAMs onto the 2x16 display.
module lcd_refresh_controller
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC   = DEF_POWERUP_CYC,
    parameter int INIT_GAP1_CYC = DEF_INIT_GAP1_CYC,
    parameter int INIT_GAP2_CYC = DEF_INIT_GAP2_CYC,
    parameter int SETUP_CYC     = DEF_SETUP_CYC,
    parameter int E_CYC         = DEF_E_CYC,
    parameter int HOLD_CYC      = DEF_HOLD_CYC,
    parameter int NIB_GAP_CYC   = DEF_NIB_GAP_CYC,
    parameter int BYTE_GAP_CYC  = DEF_BYTE_GAP_CYC,
    parameter int CLEAR_GAP_CYC = DEF_CLEAR_GAP_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_remote,
    output logic [4:0] LocalRAM_RADD,
    input  logic [7:0] LocalRAM_DOUT,
    output logic [4:0] RemoteRAM_RADD,
    input  logic [7:0] RemoteRAM_DOUT,
    output logic [3:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       init_done,
    output logic       frame_done
);

    localparam int CW =
        cntWidth(POWERUP_CYC, INIT_GAP1_CYC, CLEAR_GAP_CYC);

    lcdState_t     state;
    lcdState_t     nextSt;
    logic [CW-1:0] waitCnt;
    logic [4:0]    radd;
    logic          selQ;
    logic [7:0]    charQ;
    logic          pending;
    logic          half;
    logic          initDone;
    logic          frameDone;

    logic          nwStart;
    logic [3:0]    nwNib;
    logic          nwRs;
    logic [CW-1:0] nwGap;
    logic          nwDone;

    logic          isCmd;
    logic          single;
    logic [7:0]    cmdByte;
    logic          cmdRs;
    logic [CW-1:0] firstGap;
    logic [CW-1:0] lowGap;

    // What each writing state sends and where it goes afterwards.
    always_comb begin
        isCmd    = 1'b1;
        single   = 1'b0;
        cmdByte  = 8'h00;
        cmdRs    = 1'b0;
        firstGap = CW'(NIB_GAP_CYC);
        lowGap   = CW'(BYTE_GAP_CYC);
        nextSt   = state;
        unique case (state)
            N3A: begin
                single   = 1'b1;
                cmdByte  = {NIB_INIT3, 4'h0};
                firstGap = CW'(INIT_GAP1_CYC);
                nextSt   = N3B;
            end
            N3B: begin
                single   = 1'b1;
                cmdByte  = {NIB_INIT3, 4'h0};
                firstGap = CW'(INIT_GAP2_CYC);
                nextSt   = N3C;
            end
            N3C: begin
                single   = 1'b1;
                cmdByte  = {NIB_INIT3, 4'h0};
                firstGap = CW'(BYTE_GAP_CYC);
                nextSt   = N2;
            end
            N2: begin
                single   = 1'b1;
                cmdByte  = {NIB_INIT2, 4'h0};
                firstGap = CW'(BYTE_GAP_CYC);
                nextSt   = FUNC;
            end
            FUNC: begin
                cmdByte = CMD_FUNC;
                nextSt  = ENTRY;
            end
            ENTRY: begin
                cmdByte = CMD_ENTRY;
                nextSt  = DISP;
            end
            DISP: begin
                cmdByte = CMD_DISP;
                nextSt  = CLR;
            end
            CLR: begin
                cmdByte = CMD_CLEAR;
                lowGap  = CW'(CLEAR_GAP_CYC);
                nextSt  = FRAME_START;
            end
            CMD_L1: begin
                cmdByte = CMD_LINE1;
                nextSt  = FETCH1;
            end
            CMD_L2: begin
                cmdByte = CMD_LINE2;
                nextSt  = FETCH1;
            end
            CHAR: begin
                cmdByte = charQ;
                cmdRs   = 1'b1;
                if (radd == 5'd31)      nextSt = FRAME_START;
                else if (radd == 5'd15) nextSt = CMD_L2;
                else                    nextSt = FETCH1;
            end
            default: isCmd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            waitCnt   <= '0;
            radd      <= '0;
            selQ      <= 1'b0;
            charQ     <= '0;
            pending   <= 1'b0;
            half      <= 1'b0;
            nwStart   <= 1'b0;
            nwNib     <= '0;
            nwRs      <= 1'b0;
            nwGap     <= '0;
            initDone  <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            nwStart   <= 1'b0;
            frameDone <= 1'b0;
            if (isCmd) begin
                if (!pending) begin
                    nwStart <= 1'b1;
                    nwNib   <= cmdByte[7:4];
                    nwRs    <= cmdRs;
                    nwGap   <= firstGap;
                    pending <= 1'b1;
                end else if (nwDone) begin
                    if (!single && !half) begin
                        half    <= 1'b1;
                        nwStart <= 1'b1;
                        nwNib   <= cmdByte[3:0];
                        nwGap   <= lowGap;
                    end else begin
                        half    <= 1'b0;
                        pending <= 1'b0;
                        state   <= nextSt;
                        if (state == CLR) initDone <= 1'b1;
                        // Address 31 stays put; FRAME_START does the wrap.
                        if (state == CHAR) begin
                            if (radd == 5'd31) frameDone <= 1'b1;
                            else               radd <= radd + 5'd1;
                        end
                    end
                end
            end else begin
                unique case (state)
                    PWR_WAIT: begin
                        if (waitCnt == CW'(POWERUP_CYC - 1)) begin
                            waitCnt <= '0;
                            state   <= N3A;
                        end else begin
                            waitCnt <= waitCnt + CW'(1);
                        end
                    end
                    FRAME_START: begin
                        selQ  <= sel_remote;
                        radd  <= '0;
                        state <= CMD_L1;
                    end
                    FETCH1: state <= FETCH2;
                    // RADD settled two edges ago, RAM register one edge ago.
                    FETCH2: begin
                        charQ <= selQ ? RemoteRAM_DOUT : LocalRAM_DOUT;
                        state <= CHAR;
                    end
                    default: state <= PWR_WAIT;
                endcase
            end
        end
    end

    lcd_nibble_writer #(
        .SETUP_CYC (SETUP_CYC),
        .E_CYC     (E_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .CW        (CW)
    ) u_nib (
        .clk     (clk),
        .rst     (rst),
        .start   (nwStart),
        .nib     (nwNib),
        .rs      (nwRs),
        .gap     (nwGap),
        .lcdData (lcd_data),
        .lcdRs   (lcd_rs),
        .lcdE    (lcd_e),
        .done    (nwDone)
    );

    assign LocalRAM_RADD  = radd;
    assign RemoteRAM_RADD = radd;
    assign lcd_rw         = 1'b0;
    assign init_done      = initDone;
    assign frame_done     = frameDone;

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// Scoreboarded bench for lcd_refresh_controller with shortened
// timing: LCD nibble stream, strobe widths and frame sequencing.
module tb_lcd_refresh_controller;

    localparam int P_PWR   = 20;
    localparam int P_G1    = 10;
    localparam int P_G2    = 8;
    localparam int P_SETUP = 2;
    localparam int P_E     = 4;
    localparam int P_HOLD  = 1;
    localparam int P_NIB   = 5;
    localparam int P_BYTE  = 6;
    localparam int P_CLR   = 10;
    localparam int FRAME_NIBS = 68;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_remote = 1'b0;
    logic [4:0] lRadd;
    logic [4:0] rRadd;
    logic [7:0] lDout = 8'h00;
    logic [7:0] rDout = 8'h00;
    logic [3:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       init_done;
    logic       frame_done;

    always #5 clk = ~clk;

    lcd_refresh_controller #(
        .POWERUP_CYC   (P_PWR),
        .INIT_GAP1_CYC (P_G1),
        .INIT_GAP2_CYC (P_G2),
        .SETUP_CYC     (P_SETUP),
        .E_CYC         (P_E),
        .HOLD_CYC      (P_HOLD),
        .NIB_GAP_CYC   (P_NIB),
        .BYTE_GAP_CYC  (P_BYTE),
        .CLEAR_GAP_CYC (P_CLR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sel_remote     (sel_remote),
        .LocalRAM_RADD  (lRadd),
        .LocalRAM_DOUT  (lDout),
        .RemoteRAM_RADD (rRadd),
        .RemoteRAM_DOUT (rDout),
        .lcd_data       (lcd_data),
        .lcd_e          (lcd_e),
        .lcd_rs         (lcd_rs),
        .lcd_rw         (lcd_rw),
        .init_done      (init_done),
        .frame_done     (frame_done)
    );

    logic [7:0] localRam [32];
    logic [7:0] remoteRam [32];
    logic [7:0] localExp [32];

    // Registered-read RAM models, one cycle of latency.
    always @(posedge clk) begin
        lDout <= localRam[lRadd];
        rDout <= remoteRam[rRadd];
    end

    typedef struct {
        logic [7:0] val;
        bit         single;
    } initStep_t;

    initStep_t  initTab [8];
    logic [4:0] sbq [$];
    int vectors = 0;
    int errors  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pushNib(logic rs, logic [3:0] n);
        sbq.push_back({rs, n});
    endtask

    task automatic pushByte(logic [7:0] v, logic rs);
        pushNib(rs, v[7:4]);
        pushNib(rs, v[3:0]);
    endtask

    task automatic pushInit();
        for (int i = 0; i < 8; i++) begin
            if (initTab[i].single) pushNib(1'b0, initTab[i].val[7:4]);
            else                   pushByte(initTab[i].val, 1'b0);
        end
    endtask

    task automatic pushFrame(bit remote);
        pushByte(8'h80, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 16) pushByte(8'hC0, 1'b0);
            pushByte(remote ? remoteRam[i] : localExp[i], 1'b1);
        end
    endtask

    bit         monOn = 1'b0;
    bit         prevE = 1'b0;
    bit         prevFd = 1'b0;
    bit         prevInit = 1'b0;
    int         eCnt = 0;
    int         rsNibs = 0;
    int         frames = 0;
    int         nibIdx = 0;
    logic [3:0] prevData = 4'h0;
    logic [3:0] capData = 4'h0;
    logic [4:0] want;

    always @(negedge clk) begin
        if (monOn) begin
            if (lcd_e && !prevE) begin
                chk("setup", 32'(lcd_data), 32'(prevData));
                capData = lcd_data;
                eCnt = 1;
                if (lcd_rs) rsNibs++;
                if (sbq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL nibble[%0d]: got rs=%0b data=%0h, required none",
                             nibIdx, lcd_rs, lcd_data);
                end else begin
                    want = sbq.pop_front();
                    chk($sformatf("nibble[%0d]", nibIdx),
                        32'({lcd_rs, lcd_data}), 32'(want));
                end
                nibIdx++;
            end else if (lcd_e) begin
                eCnt++;
            end else if (prevE) begin
                chk("e_width", 32'(eCnt), 32'(P_E));
                chk("hold", 32'(lcd_data), 32'(capData));
            end
            if (frame_done) begin
                chk("fd_width", 32'(prevFd), 32'(0));
                if (!prevFd) begin
                    chk("fd_chars", 32'(rsNibs), 32'(64));
                    rsNibs = 0;
                    frames++;
                end
            end
            if (prevInit != init_done) chk("init_sticky", 32'(init_done), 32'(1));
        end
        prevE = lcd_e;
        prevFd = frame_done;
        prevInit = init_done;
        prevData = lcd_data;
    end

    task automatic checkQuiet(string name);
        bit sawE;
        sawE = 1'b0;
        repeat (P_PWR) begin
            @(negedge clk);
            if (lcd_e || lcd_data != 4'h0) sawE = 1'b1;
        end
        chk(name, 32'(sawE), 32'(0));
    endtask

    initial begin
        initTab[0] = '{8'h30, 1'b1};
        initTab[1] = '{8'h30, 1'b1};
        initTab[2] = '{8'h30, 1'b1};
        initTab[3] = '{8'h20, 1'b1};
        initTab[4] = '{8'h28, 1'b0};
        initTab[5] = '{8'h06, 1'b0};
        initTab[6] = '{8'h0C, 1'b0};
        initTab[7] = '{8'h01, 1'b0};
        for (int i = 0; i < 32; i++) begin
            localRam[i]  = 8'h41 + 8'(i);
            localExp[i]  = 8'h41 + 8'(i);
            remoteRam[i] = 8'h30 + 8'(i);
        end
        localExp[5] = 8'h7A;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 32'(0));
        chk("rst_data", 32'(lcd_data), 32'(0));
        chk("rst_rs", 32'(lcd_rs), 32'(0));
        chk("rst_rw", 32'(lcd_rw), 32'(0));
        chk("rst_init", 32'(init_done), 32'(0));
        chk("rst_fd", 32'(frame_done), 32'(0));
        chk("rst_ladd", 32'(lRadd), 32'(0));
        chk("rst_radd", 32'(rRadd), 32'(0));

        pushInit();
        pushFrame(1'b0);
        pushFrame(1'b1);
        pushFrame(1'b1);
        monOn = 1'b1;
        rst = 1'b0;
        checkQuiet("pwr_quiet");

        for (int c = 0; c < LIMIT && !init_done; c++) @(negedge clk);
        chk("init_done_rise", 32'(init_done), 32'(1));
        chk("init_then_frame", 32'(sbq.size()), 32'(3 * FRAME_NIBS));

        for (int c = 0; c < LIMIT && lRadd != 5'd2; c++) @(negedge clk);
        chk("radd_2", 32'(lRadd), 32'(2));
        localRam[5] = 8'h7A;

        for (int c = 0; c < LIMIT && lRadd != 5'd10; c++) @(negedge clk);
        chk("radd_10", 32'(lRadd), 32'(10));
        sel_remote = 1'b1;

        for (int c = 0; c < LIMIT && frames < 2; c++) @(negedge clk);
        chk("two_frames", 32'(frames), 32'(2));
        chk("sb_two_frames", 32'(sbq.size()), 32'(FRAME_NIBS));

        for (int c = 0; c < LIMIT && !(lcd_e && lcd_rs); c++) @(negedge clk);
        chk("mid_char_e", 32'({lcd_e, lcd_rs}), 32'(3));
        monOn = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_e", 32'(lcd_e), 32'(0));
        chk("abort_init", 32'(init_done), 32'(0));
        chk("abort_radd", 32'(lRadd), 32'(0));
        chk("abort_data", 32'(lcd_data), 32'(0));
        repeat (2) @(negedge clk);
        sbq.delete();
        pushInit();
        pushFrame(1'b1);
        rsNibs = 0;
        monOn = 1'b1;
        rst = 1'b0;
        checkQuiet("pwr_quiet_2");

        for (int c = 0; c < LIMIT && !init_done; c++) @(negedge clk);
        chk("reinit_done", 32'(init_done), 32'(1));
        chk("reinit_then_frame", 32'(sbq.size()), 32'(FRAME_NIBS));

        for (int c = 0; c < LIMIT && frames < 3; c++) @(negedge clk);
        chk("third_frame", 32'(frames), 32'(3));
        chk("sb_drained", 32'(sbq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
